// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin grant, one-cycle issue, registered response.
// Port 0 is the core LSU, port 1 the debug/DMA loader. Alignment and range are checked
// before issue; a bad access skips the write and returns err_o with zero data.
module dmem_arbiter #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  ADDR_LIMIT = 32'h0001_FFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] addr0,
  input  logic                  we0,
  input  logic [2:0]            ctrl0,
  input  logic [DATA_WIDTH-1:0] wd0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] addr1,
  input  logic                  we1,
  input  logic [2:0]            ctrl1,
  input  logic [DATA_WIDTH-1:0] wd1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rd_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] mem_a,
  output logic [2:0]            mem_ctrl,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e                r_state;
  logic                  r_ptr;
  logic                  r_owner;
  logic [DATA_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [2:0]            r_ctrl;
  logic [DATA_WIDTH-1:0] r_wd;
  logic                  r_bad;
  logic [DATA_WIDTH-1:0] r_rd;
  logic                  r_err;
  logic                  r_rvalid0;
  logic                  r_rvalid1;

  logic                  w_accept;
  logic                  w_pick1;
  logic                  w_any;
  logic [DATA_WIDTH-1:0] w_addr;
  logic                  w_we;
  logic [2:0]            w_ctrl;
  logic [DATA_WIDTH-1:0] w_wd;
  logic [DATA_WIDTH:0]   w_size;
  logic [DATA_WIDTH:0]   w_last;
  logic                  w_misalign;
  logic                  w_bad;

  // Grant decision: only in IDLE/RESP; pointer breaks ties, a lone requester always wins.
  always_comb begin
    w_accept = rst_n & (r_state != StIssue);
    w_pick1  = req1 & (~req0 | r_ptr);
    gnt0     = w_accept & req0 & ~w_pick1;
    gnt1     = w_accept & w_pick1;
    w_any    = gnt0 | gnt1;
  end

  // Winner field mux and the bad-access check on the fields about to be latched.
  always_comb begin
    w_addr = w_pick1 ? addr1 : addr0;
    w_we   = w_pick1 ? we1   : we0;
    w_ctrl = w_pick1 ? ctrl1 : ctrl0;
    w_wd   = w_pick1 ? wd1   : wd0;
    unique case (w_ctrl[1:0])
      2'b00:   w_size = (DATA_WIDTH+1)'(1);
      2'b01:   w_size = (DATA_WIDTH+1)'(2);
      2'b10:   w_size = (DATA_WIDTH+1)'(4);
      default: w_size = (DATA_WIDTH+1)'(1);
    endcase
    // One extra bit so an access near the top of the address space cannot wrap to a small value.
    w_last     = {1'b0, w_addr} + w_size - (DATA_WIDTH+1)'(1);
    w_misalign = ((w_ctrl[1:0] == 2'b01) && w_addr[0]) ||
                 ((w_ctrl[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
    w_bad      = (w_ctrl[1:0] == 2'b11) || w_misalign || (w_last > {1'b0, ADDR_LIMIT});
  end

  // Arbiter FSM: latch on grant, issue for one cycle, then strobe the owner's rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_ptr     <= 1'b0;
      r_owner   <= 1'b0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_ctrl    <= '0;
      r_wd      <= '0;
      r_bad     <= 1'b0;
      r_rd      <= '0;
      r_err     <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      unique case (r_state)
        StIdle, StResp: begin
          if (w_any) begin
            r_owner <= w_pick1;
            r_addr  <= w_addr;
            r_we    <= w_we;
            r_ctrl  <= w_ctrl;
            r_wd    <= w_wd;
            r_bad   <= w_bad;
            r_ptr   <= ~w_pick1;
            r_state <= StIssue;
          end else begin
            r_state <= StIdle;
          end
        end
        StIssue: begin
          r_rd      <= (r_bad | r_we) ? '0 : mem_rd;
          r_err     <= r_bad;
          r_rvalid0 <= ~r_owner;
          r_rvalid1 <= r_owner;
          r_state   <= StResp;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Memory side holds the last latched request; the write strobe exists only in ISSUE.
  always_comb begin
    mem_a    = r_addr;
    mem_ctrl = r_ctrl;
    mem_wd   = r_wd;
    mem_we   = rst_n & (r_state == StIssue) & r_we & ~r_bad;
    rd_o     = r_rd;
    err_o    = r_err;
    rvalid0  = r_rvalid0;
    rvalid1  = r_rvalid1;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressable memory model behind it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wd0, wd1;
  logic [2:0]  ctrl0, ctrl1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err_o, mem_we;
  logic [31:0] rd_o, mem_a, mem_wd, mem_rd;
  logic [2:0]  mem_ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_LIMIT(32'h0001_FFFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .we0(we0), .ctrl0(ctrl0), .wd0(wd0),
    .req1(req1), .addr1(addr1), .we1(we1), .ctrl1(ctrl1), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rd_o(rd_o), .err_o(err_o),
    .mem_a(mem_a), .mem_ctrl(mem_ctrl), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Little-endian byte memory; size/sign handling lives here, as in the real data memory.
  logic [7:0]  mem [0:131071];
  logic [16:0] m_idx;
  always_comb begin
    m_idx = mem_a[16:0];
    case (mem_ctrl[1:0])
      2'b00:   mem_rd = {{24{~mem_ctrl[2] & mem[m_idx][7]}}, mem[m_idx]};
      2'b01:   mem_rd = {{16{~mem_ctrl[2] & mem[m_idx+17'd1][7]}}, mem[m_idx+17'd1], mem[m_idx]};
      default: mem_rd = {mem[m_idx+17'd3], mem[m_idx+17'd2], mem[m_idx+17'd1], mem[m_idx]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_ctrl[1:0])
        2'b00: mem[m_idx] <= mem_wd[7:0];
        2'b01: begin
          mem[m_idx]       <= mem_wd[7:0];
          mem[m_idx+17'd1] <= mem_wd[15:8];
        end
        default: begin
          mem[m_idx]       <= mem_wd[7:0];
          mem[m_idx+17'd1] <= mem_wd[15:8];
          mem[m_idx+17'd2] <= mem_wd[23:16];
          mem[m_idx+17'd3] <= mem_wd[31:24];
        end
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete access on a port; returns response data, error and the ISSUE-cycle mem_we.
  task automatic access(input int port, input logic [31:0] a, input logic we,
                        input logic [2:0] c, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output logic we_seen);
    int k = 0;
    if (port == 0) begin
      addr0 = a; we0 = we; ctrl0 = c; wd0 = wd; req0 = 1'b1;
    end else begin
      addr1 = a; we1 = we; ctrl1 = c; wd1 = wd; req1 = 1'b1;
    end
    #1;
    while (((port == 0) ? gnt0 : gnt1) !== 1'b1 && k < 20) begin
      @(negedge clk); #1; k++;
    end
    check_eq("gnt_seen", {31'd0, k < 20}, 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    we_seen = mem_we;
    check_eq("issue_no_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
    @(negedge clk);
    check_eq("rvalid_route", {30'd0, rvalid0, rvalid1}, (port == 0) ? 32'd2 : 32'd1);
    rd  = rd_o;
    err = err_o;
  endtask

  logic [31:0] rd;
  logic        err, wes;
  logic [3:0]  exp_pat [0:7];
  logic [31:0] exp_rd  [0:7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wd0 = 0; wd1 = 0; ctrl0 = 0; ctrl1 = 0;
    #1;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    // Reset state: everything low, even with both requests up.
    check_eq("rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    check_eq("rst_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
    check_eq("rst_rd", rd_o, 32'd0);
    check_eq("rst_err_we", {30'd0, err_o, mem_we}, 32'd0);
    check_eq("rst_mem_a", mem_a, 32'd0);
    check_eq("rst_mem_ctrl_wd", mem_wd | {29'd0, mem_ctrl}, 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Store word then byte loads (sign and zero extend) on port 0.
    access(0, 32'h0001_0000, 1'b1, 3'b010, 32'hDEAD_BEEF, rd, err, wes);
    check_eq("st_we", {31'd0, wes}, 32'd1);
    check_eq("st_rd_err", rd | {31'd0, err}, 32'd0);
    access(0, 32'h0001_0010, 1'b1, 3'b010, 32'h1122_3344, rd, err, wes);
    check_eq("st2_we", {31'd0, wes}, 32'd1);
    access(0, 32'h0001_0003, 1'b0, 3'b000, 32'd0, rd, err, wes);
    check_eq("ldb_sext", rd, 32'hFFFF_FFDE);
    check_eq("ldb_err", {31'd0, err}, 32'd0);
    check_eq("ld_no_we", {31'd0, wes}, 32'd0);
    access(0, 32'h0001_0003, 1'b0, 3'b100, 32'd0, rd, err, wes);
    check_eq("ldbu_zext", rd, 32'h0000_00DE);

    // Misaligned store from port 1 must not write.
    access(1, 32'h0001_0002, 1'b1, 3'b010, 32'h1234_5678, rd, err, wes);
    check_eq("mis_we", {31'd0, wes}, 32'd0);
    check_eq("mis_err", {31'd0, err}, 32'd1);
    check_eq("mis_rd", rd, 32'd0);
    access(1, 32'h0001_0000, 1'b0, 3'b010, 32'd0, rd, err, wes);
    check_eq("mis_unchanged", rd, 32'hDEAD_BEEF);
    access(0, 32'h0001_0001, 1'b0, 3'b001, 32'd0, rd, err, wes);
    check_eq("half_odd_err", {31'd0, err}, 32'd1);
    access(0, 32'h0001_0000, 1'b0, 3'b011, 32'd0, rd, err, wes);
    check_eq("illegal_size_err", {31'd0, err}, 32'd1);

    // Range boundary.
    access(0, 32'h0001_FFFF, 1'b0, 3'b001, 32'd0, rd, err, wes);
    check_eq("half_top_err", {31'd0, err}, 32'd1);
    check_eq("half_top_rd", rd, 32'd0);
    access(0, 32'h0001_FFFF, 1'b0, 3'b000, 32'd0, rd, err, wes);
    check_eq("byte_top_ok", {31'd0, err}, 32'd0);
    access(1, 32'h0001_FFFC, 1'b0, 3'b010, 32'd0, rd, err, wes);
    check_eq("word_top_ok", {31'd0, err}, 32'd0);
    access(1, 32'hFFFF_FFFC, 1'b0, 3'b010, 32'd0, rd, err, wes);
    check_eq("word_wrap_err", {31'd0, err}, 32'd1);

    // Withdrawn request: req1 pulses during port 0's ISSUE cycle.
    addr0 = 32'h0001_0000; we0 = 1'b0; ctrl0 = 3'b010; req0 = 1'b1;
    #1;
    check_eq("wd_gnt0", {30'd0, gnt0, gnt1}, 32'd2);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b1; addr1 = 32'h0001_0000; we1 = 1'b0; ctrl1 = 3'b010;
    @(negedge clk);
    check_eq("wd_issue_no_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    @(posedge clk); #1;
    req1 = 1'b0;
    @(negedge clk);
    check_eq("wd_rvalid0_only", {30'd0, rvalid0, rvalid1}, 32'd2);
    check_eq("wd_rd", rd_o, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("wd_no_port1", {30'd0, gnt1, rvalid1}, 32'd0);
    end

    // Reset during ISSUE of a store aborts the write.
    addr0 = 32'h0001_0010; we0 = 1'b1; ctrl0 = 3'b010; wd0 = 32'hCAFE_F00D; req0 = 1'b1;
    #1;
    check_eq("mid_gnt0", {30'd0, gnt0, gnt1}, 32'd2);
    @(posedge clk); #1;
    req0 = 1'b0;
    check_eq("mid_issue_we", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_we_drop", {31'd0, mem_we}, 32'd0);
    check_eq("mid_rst_mem_a", mem_a, 32'd0);
    addr0 = 32'h0001_0000; we0 = 1'b0; ctrl0 = 3'b010;
    addr1 = 32'h0001_0010; we1 = 1'b0; ctrl1 = 3'b010;
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Continuous contention from reset: {gnt0,gnt1,rvalid0,rvalid1} per cycle.
    exp_pat[0] = 4'b1000; exp_pat[1] = 4'b0000; exp_pat[2] = 4'b0110; exp_pat[3] = 4'b0000;
    exp_pat[4] = 4'b1001; exp_pat[5] = 4'b0000; exp_pat[6] = 4'b0110; exp_pat[7] = 4'b0000;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0; exp_rd[2] = 32'hDEAD_BEEF; exp_rd[3] = 32'hDEAD_BEEF;
    exp_rd[4] = 32'h1122_3344; exp_rd[5] = 32'h1122_3344;
    exp_rd[6] = 32'hDEAD_BEEF; exp_rd[7] = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("cont_pat%0d", i), {28'd0, gnt0, gnt1, rvalid0, rvalid1},
               {28'd0, exp_pat[i]});
      check_eq($sformatf("cont_rd%0d", i), rd_o, exp_rd[i]);
      if (i == 0) begin
        check_eq("rel_outputs", mem_a | mem_wd | {28'd0, mem_ctrl, mem_we}, 32'd0);
        check_eq("rel_err", {31'd0, err_o}, 32'd0);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check_eq("cont_tail", {28'd0, gnt0, gnt1, rvalid0, rvalid1}, 32'd1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
